// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encodings,
// iteration count, counter width and the operand-magnitude helper.
package multdiv_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/multdiv_booth_step.sv
// One radix-2 Booth iteration: add/subtract the multiplicand into the upper
// half according to the low two register bits, then arithmetic-shift right by 1.
module booth_step
    import multdiv_pkg::*;
(
    input  logic [2*DATA_W:0]  i_booth,
    input  logic [DATA_W-1:0]  i_mcand,
    output logic [2*DATA_W:0]  o_next
);

    logic [DATA_W:0] w_upper;
    logic [DATA_W:0] w_mcand;
    logic [DATA_W:0] w_sum;

    // Sum is formed one bit wider so subtracting 0x80000000 cannot wrap; after
    // the shift the top DATA_W bits of that sum are the exact new upper half.
    always_comb begin
        w_upper = {i_booth[2*DATA_W], i_booth[2*DATA_W:DATA_W+1]};
        w_mcand = {i_mcand[DATA_W-1], i_mcand};
        case (i_booth[1:0])
            2'b01:   w_sum = w_upper + w_mcand;
            2'b10:   w_sum = w_upper - w_mcand;
            default: w_sum = w_upper;
        endcase
        o_next = {w_sum[DATA_W:1], w_sum[0], i_booth[DATA_W:2], i_booth[1]};
    end

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// Define MULTDIV_DIV_EN to build the divider; without it every divide
// completes immediately with result 0 and the exception flag set.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(ITER - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH:0]   r_booth;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;

    logic [2*WIDTH:0]   w_booth_next;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_ovf;
    logic               w_last;

    booth_step u_booth_step (
        .i_booth (r_booth),
        .i_mcand (r_mcand),
        .o_next  (w_booth_next)
    );

    // Multiply overflow: product bits 63..31 must be a pure sign extension.
    always_comb begin
        w_prod_hi = w_booth_next[2*WIDTH:WIDTH];
        w_mul_ovf = ~((&w_prod_hi) | ~(|w_prod_hi));
        w_last    = (r_cnt == LP_CNT_LAST);
    end

`ifdef MULTDIV_DIV_EN
    logic               r_neg;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_signed;
    logic               w_div_ovf;

    // Restoring step: dividend bits shift out of r_quo as quotient bits shift in.
    always_comb begin
        w_shift      = {r_rem, r_quo[WIDTH-1]};
        w_diff       = w_shift - {1'b0, r_dvs};
        w_fit        = ~w_diff[WIDTH];
        w_rem_next   = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_next   = {r_quo[WIDTH-2:0], w_fit};
        w_quo_signed = r_neg ? -w_quo_next : w_quo_next;
        w_div_ovf    = ~r_neg & w_quo_next[WIDTH-1];
    end

    // Divider datapath registers, loaded on a divide start and stepped in DIV.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_neg <= 1'b0;
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (!ctrl_MULT && ctrl_DIV) begin
            r_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_rem <= '0;
            r_quo <= f_mag(data_operandA);
            r_dvs <= f_mag(data_operandB);
        end else if (r_state == ST_DIV) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
        end
    end
`endif

    // Control FSM, Booth register and the registered result outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_booth  <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (ctrl_MULT) begin
                r_state <= ST_MUL;
                r_cnt   <= '0;
                r_mcand <= data_operandA;
                r_booth <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            end else if (ctrl_DIV) begin
                r_cnt <= '0;
`ifdef MULTDIV_DIV_EN
                if (data_operandB == '0) begin
                    r_state  <= ST_DONE;
                    r_result <= '0;
                    r_exc    <= 1'b1;
                    r_rdy    <= 1'b1;
                end else begin
                    r_state <= ST_DIV;
                end
`else
                r_state  <= ST_DONE;
                r_result <= '0;
                r_exc    <= 1'b1;
                r_rdy    <= 1'b1;
`endif
            end else begin
                case (r_state)
                    ST_MUL: begin
                        r_booth <= w_booth_next;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state  <= ST_DONE;
                            r_result <= w_booth_next[WIDTH:1];
                            r_exc    <= w_mul_ovf;
                            r_rdy    <= 1'b1;
                        end
                    end
`ifdef MULTDIV_DIV_EN
                    ST_DIV: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state  <= ST_DONE;
                            r_result <= w_quo_signed;
                            r_exc    <= w_div_ovf;
                            r_rdy    <= 1'b1;
                        end
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv.sv
// Randomized + directed bench for multdiv with an arithmetic reference model.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] opA, opB;
    logic        cm, cd;
    logic [31:0] res;
    logic        exc, rdy;

    int n_checks = 0;
    int n_fails  = 0;

    localparam longint MAXI = 64'sh7FFFFFFF;
    localparam longint MINI = -64'sh80000000;

    multdiv #(.WIDTH(32), .ITER(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (opA),
        .data_operandB  (opB),
        .ctrl_MULT      (cm),
        .ctrl_DIV       (cd),
        .data_result    (res),
        .data_exception (exc),
        .data_resultRDY (rdy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // op: 0 = multiply, 1 = divide, 2 = both controls high (multiply wins)
    task automatic model(input int op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic e, output int lat);
        longint p;
        longint q;
        if (op != 1) begin
            p   = longint'($signed(x)) * longint'($signed(y));
            r   = p[31:0];
            e   = (p > MAXI) || (p < MINI);
            lat = 32;
        end else if (y == 32'd0) begin
            r = 32'd0; e = 1'b1; lat = 0;
        end else begin
`ifdef MULTDIV_DIV_EN
            q   = longint'($signed(x)) / longint'($signed(y));
            r   = q[31:0];
            e   = (q > MAXI);
            lat = 32;
`else
            q   = 0;
            r   = q[31:0]; e = 1'b1; lat = 0;
`endif
        end
    endtask

    // Issue a start on the next edge, then check latency and outputs at RDY.
    task automatic run_op(input int op, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] er;
        logic        ee;
        int          lat;
        int          n;
        model(op, x, y, er, ee, lat);
        opA = x; opB = y;
        cm = (op != 1); cd = (op != 0);
        @(posedge clock); #1;
        cm = 1'b0; cd = 1'b0;
        opA = $urandom; opB = $urandom;
        n = 0;
        while (!rdy && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " rdy"}, {31'd0, rdy}, 32'd1);
        check({tag, " result"}, res, er);
        check({tag, " exception"}, {31'd0, exc}, {31'd0, ee});
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clock); #1;
        check({tag, " rdy pulse width"}, {31'd0, rdy}, 32'd0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int k;
        k = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (rdy) k++;
        end
        check({tag, " stray rdy"}, k, 0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] t;
        case ($urandom_range(0, 6))
            0: t = 32'd0;
            1: t = 32'h80000000;
            2: t = 32'hFFFFFFFF;
            3: t = $urandom_range(0, 20);
            4: begin t = $urandom_range(1, 20); t = -t; end
            default: t = $urandom;
        endcase
        return t;
    endfunction

    initial begin
        reset = 1'b1; cm = 1'b0; cd = 1'b0; opA = '0; opB = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset result", res, 32'd0);
        check("reset exception", {31'd0, exc}, 32'd0);
        check("reset rdy", {31'd0, rdy}, 32'd0);
        reset = 1'b0;

        run_op(0, 32'd7, 32'hFFFFFFFA, "mul 7x-6");
        pulse_end("mul 7x-6");
        run_op(0, 32'h00010000, 32'h00010000, "mul ovf");
        pulse_end("mul ovf");
        run_op(1, 32'hFFFFFFF9, 32'd2, "div -7/2");
        run_op(1, 32'd100, 32'd7, "div 100/7 b2b");
        pulse_end("div 100/7 b2b");
        run_op(1, 32'd5, 32'd0, "div by zero");
        pulse_end("div by zero");
        run_op(1, 32'h80000000, 32'hFFFFFFFF, "div ovf");
        pulse_end("div ovf");
        run_op(2, 32'd9, 32'hFFFFFFFF, "both ctrl");
        pulse_end("both ctrl");
        run_op(0, 32'h80000000, 32'h80000000, "mul min*min");
        pulse_end("mul min*min");

        // Abort: multiply superseded by a divide 10 cycles later
        opA = 32'd3; opB = 32'd4; cm = 1'b1;
        @(posedge clock); #1;
        cm = 1'b0;
        watch_quiet("abort pre", 9);
        run_op(1, 32'd100, 32'd7, "abort div");
        pulse_end("abort div");
        watch_quiet("abort post", 40);

        // Asynchronous reset in the middle of a multiply
        run_op(0, 32'd6, 32'd7, "pre-reset mul");
        pulse_end("pre-reset mul");
        opA = 32'd3; opB = 32'd5; cm = 1'b1;
        @(posedge clock); #1;
        cm = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async reset result", res, 32'd0);
        check("async reset exception", {31'd0, exc}, 32'd0);
        check("async reset rdy", {31'd0, rdy}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        watch_quiet("after reset", 40);
        run_op(0, 32'd6, 32'd7, "post-reset mul");
        pulse_end("post-reset mul");

        // Random operations, about half issued back-to-back on the DONE cycle
        for (int i = 0; i < 60; i++) begin
            run_op($urandom_range(0, 2), pick(), pick(), $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 0) pulse_end($sformatf("rand%0d", i));
        end
        pulse_end("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
